// File: rtl/light_seq_pkg.sv
// Shared types and LFSR tap rule for the start-light sequencer.
package light_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int unsigned LFSR_SEED = 1;

  // Fibonacci step, shift left; feedback from the two top bits of a w-bit register.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q, input int unsigned w);
    logic fb;
    fb = q[5'(w - 1)] ^ q[5'(w - 2)];
    return {q[30:0], fb};
  endfunction

endpackage

// File: rtl/seq_lfsr.sv
// Free-running LFSR supplying the pseudo-random hold length; reseeds to LFSR_SEED on load.
module seq_lfsr
  import light_seq_pkg::*;
#(
  parameter int unsigned LFSR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = load ? LFSR_W'(LFSR_SEED) : LFSR_W'(lfsr_next(32'(q_q), LFSR_W));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= LFSR_W'(LFSR_SEED);
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/light_sequencer.sv
// Start-light sequencer: fills the bank one light per tick, holds for a random
// number of ticks, then blanks the bank and pulses lfsr_begin.
module light_sequencer
  import light_seq_pkg::*;
#(
  parameter int unsigned N_LIGHTS = 8,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned LFSR_W   = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic                lfsr_reset,
  input  logic                run,
  output logic [N_LIGHTS-1:0] lights,
  output logic                lfsr_begin,
  output logic [LFSR_W-1:0]   lfsr_val,
  output logic [1:0]          seq_state
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  seq_state_t          state_q;
  logic [PW-1:0]       presc_q;
  logic [N_LIGHTS-1:0] lights_q;
  logic [LFSR_W-1:0]   hold_q;
  logic                begin_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic                tick;

  seq_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .load  (lfsr_reset),
    .q     (lfsr_q)
  );

  // Prescaler only runs in FILL/HOLD, so tick is never seen in IDLE/DONE.
  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      lights_q <= '0;
      hold_q   <= '0;
      begin_q  <= 1'b0;
    end else begin
      // The begin pulse is one cycle wide even if en drops right after it.
      begin_q <= 1'b0;
      if (clr) begin
        state_q  <= IDLE;
        presc_q  <= '0;
        lights_q <= '0;
        hold_q   <= '0;
      end else if (en) begin
        unique case (state_q)
          IDLE: begin
            lights_q <= '0;
            presc_q  <= '0;
            if (run) state_q <= FILL;
          end
          FILL: begin
            if (!run) begin
              state_q  <= IDLE;
              lights_q <= '0;
              presc_q  <= '0;
            end else if (tick) begin
              presc_q <= '0;
              if (&lights_q) begin
                state_q <= HOLD;
                hold_q  <= lfsr_q;
              end else begin
                lights_q <= {lights_q[N_LIGHTS-2:0], 1'b1};
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
          HOLD: begin
            if (!run) begin
              state_q  <= IDLE;
              lights_q <= '0;
              presc_q  <= '0;
            end else if (tick) begin
              presc_q <= '0;
              if (hold_q == LFSR_W'(1)) begin
                state_q  <= DONE;
                lights_q <= '0;
                begin_q  <= 1'b1;
              end else begin
                hold_q <= hold_q - LFSR_W'(1);
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
          DONE: begin
            lights_q <= '0;
            presc_q  <= '0;
            if (!run) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign lights     = lights_q;
  assign lfsr_begin = begin_q;
  assign lfsr_val   = lfsr_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: stimulus queues timed expectations, a monitor checks them.
module tb_light_sequencer;

  localparam int unsigned TD = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_FILL = 2'd1, S_HOLD = 2'd2, S_DONE = 2'd3;
  localparam logic [3:0] M_L = 4'b0001, M_V = 4'b0010, M_S = 4'b0100, M_B = 4'b1000;

  logic       clk = 1'b0;
  logic       reset, clr, en, lfsr_reset, run;
  logic [7:0] lights;
  logic       lfsr_begin;
  logic [6:0] lfsr_val;
  logic [1:0] seq_state;

  light_sequencer #(.N_LIGHTS(8), .TICK_DIV(TD), .LFSR_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .en         (en),
    .lfsr_reset (lfsr_reset),
    .run        (run),
    .lights     (lights),
    .lfsr_begin (lfsr_begin),
    .lfsr_val   (lfsr_val),
    .seq_state  (seq_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    string       name;
    logic [3:0]  mask;
    logic [7:0]  lights;
    logic [6:0]  lfsr;
    logic [1:0]  st;
    logic        bgn;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  logic [6:0]  m_lfsr;
  event        chk_ev;
  logic [6:0]  tbl [8] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};

  function automatic logic [6:0] nx(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  function automatic logic [6:0] adv(input logic [6:0] v, input int n);
    logic [6:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = nx(r);
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: seed on reset/reseed, step on every enabled edge.
  always @(posedge clk or posedge reset) begin
    if (reset)         m_lfsr <= 7'h01;
    else if (en)       m_lfsr <= lfsr_reset ? 7'h01 : nx(m_lfsr);
  end

  always @(negedge clk) if (lfsr_begin === 1'b1) pulses++;

  task automatic push(input int unsigned at, input string name, input logic [3:0] mask,
                      input logic [7:0] l, input logic [6:0] v, input logic [1:0] s,
                      input logic b);
    exp_t e;
    e.at = at; e.name = name; e.mask = mask;
    e.lights = l; e.lfsr = v; e.st = s; e.bgn = b;
    sb.push_back(e);
  endtask

  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      exp_t e;
      logic ok;
      e = sb[i];
      if (e.at <= cyc) begin
        sb.delete(i);
        total++;
        ok = (e.at == cyc);
        if (e.mask[0] && lights !== e.lights)      ok = 1'b0;
        if (e.mask[1] && lfsr_val !== e.lfsr)      ok = 1'b0;
        if (e.mask[2] && seq_state !== e.st)       ok = 1'b0;
        if (e.mask[3] && lfsr_begin !== e.bgn)     ok = 1'b0;
        if (!ok) begin
          bad++;
          $display("FAIL %s @%0d (due %0d): got lights=%h lfsr=%h st=%0d begin=%b, want lights=%h lfsr=%h st=%0d begin=%b mask=%b",
                   e.name, cyc, e.at, lights, lfsr_val, seq_state, lfsr_begin,
                   e.lights, e.lfsr, e.st, e.bgn, e.mask);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or chk_ev);
      check_due();
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, f, h, v;
    logic [6:0]  mc;

    reset = 1'b1; clr = 1'b0; en = 1'b1; lfsr_reset = 1'b0; run = 1'b0;
    step(2);
    push(cyc, "reset_state", 4'hF, 8'h00, 7'h01, S_IDLE, 1'b0);
    ->chk_ev;
    #1 reset = 1'b0;

    // LFSR stepping while idle, then full-period wrap.
    c0 = cyc;
    for (int k = 1; k < 8; k++) push(c0 + k, "lfsr_seq", M_V | M_S | M_L, 8'h00, tbl[k], S_IDLE, 1'b0);
    push(c0 + 127, "lfsr_wrap", M_V | M_S, 8'h00, 7'h01, S_IDLE, 1'b0);
    step(128);

    // Fill, hold for the captured LFSR value, pulse, return to IDLE.
    mc = m_lfsr; f = cyc + 1; h = f + 36; v = int'(adv(mc, 36));
    run = 1'b1;
    push(f,      "fill_enter", 4'hF, 8'h00, adv(mc, 1), S_FILL, 1'b0);
    push(f + 3,  "fill_pre1",  M_L | M_S, 8'h00, 7'h00, S_FILL, 1'b0);
    push(f + 4,  "fill_1",     M_L | M_S, 8'h01, 7'h00, S_FILL, 1'b0);
    push(f + 8,  "fill_2",     M_L | M_S, 8'h03, 7'h00, S_FILL, 1'b0);
    push(f + 32, "fill_full",  M_L | M_S, 8'hFF, 7'h00, S_FILL, 1'b0);
    push(f + 35, "fill_last",  M_L | M_S, 8'hFF, 7'h00, S_FILL, 1'b0);
    push(h,      "hold_enter", 4'hF, 8'hFF, adv(mc, 37), S_HOLD, 1'b0);
    push(h + 4 * v - 1, "hold_last", M_L | M_S | M_B, 8'hFF, 7'h00, S_HOLD, 1'b0);
    push(h + 4 * v,     "pulse",     M_L | M_S | M_B, 8'h00, 7'h00, S_DONE, 1'b1);
    push(h + 4 * v + 1, "pulse_end", M_L | M_S | M_B, 8'h00, 7'h00, S_DONE, 1'b0);
    step(h + 4 * v + 1 - cyc);
    run = 1'b0;
    push(cyc + 1, "done_idle", M_L | M_S | M_B, 8'h00, 7'h00, S_IDLE, 1'b0);
    step(2);

    // Abort in FILL at lights=07.
    f = cyc + 1;
    run = 1'b1;
    push(f + 12, "abort_f_07", M_L | M_S, 8'h07, 7'h00, S_FILL, 1'b0);
    step(f + 12 - cyc);
    run = 1'b0;
    push(cyc + 1, "abort_f_idle", M_L | M_S | M_B, 8'h00, 7'h00, S_IDLE, 1'b0);
    step(3);

    // Abort in HOLD.
    f = cyc + 1; h = f + 36;
    run = 1'b1;
    push(h, "abort_h_hold", M_L | M_S, 8'hFF, 7'h00, S_HOLD, 1'b0);
    step(h + 2 - cyc);
    run = 1'b0;
    push(cyc + 1, "abort_h_idle", M_L | M_S | M_B, 8'h00, 7'h00, S_IDLE, 1'b0);
    push(cyc + 2, "abort_h_quiet", M_L | M_S | M_B, 8'h00, 7'h00, S_IDLE, 1'b0);
    step(3);

    // Freeze for 10 cycles mid-HOLD; completion slips by exactly 10 cycles.
    mc = m_lfsr; f = cyc + 1; h = f + 36; v = int'(adv(mc, 36));
    run = 1'b1;
    push(h, "frz_hold", M_L | M_S, 8'hFF, 7'h00, S_HOLD, 1'b0);
    step(h + 1 - cyc);
    mc = m_lfsr;
    en = 1'b0;
    push(h + 6,  "frz_mid",    4'hF, 8'hFF, mc, S_HOLD, 1'b0);
    push(h + 11, "frz_resume", 4'hF, 8'hFF, mc, S_HOLD, 1'b0);
    push(h + 4 * v + 9,  "frz_last",      M_L | M_S | M_B, 8'hFF, 7'h00, S_HOLD, 1'b0);
    push(h + 4 * v + 10, "frz_pulse",     M_L | M_S | M_B, 8'h00, 7'h00, S_DONE, 1'b1);
    push(h + 4 * v + 11, "frz_pulse_end", M_L | M_S | M_B, 8'h00, 7'h00, S_DONE, 1'b0);
    step(10);
    en = 1'b1;
    step(h + 4 * v + 11 - cyc);
    run = 1'b0;
    step(2);

    // clr mid-FILL with run held: IDLE for two cycles, LFSR keeps stepping.
    f = cyc + 1;
    run = 1'b1;
    push(f + 8, "clr_pre", M_L | M_S, 8'h03, 7'h00, S_FILL, 1'b0);
    step(f + 9 - cyc);
    mc = m_lfsr;
    clr = 1'b1;
    push(f + 10, "clr_idle",  4'hF, 8'h00, adv(mc, 1), S_IDLE, 1'b0);
    push(f + 11, "clr_wins",  4'hF, 8'h00, adv(mc, 2), S_IDLE, 1'b0);
    step(2);
    clr = 1'b0;
    push(f + 12, "clr_refill",  M_L | M_S, 8'h00, 7'h00, S_FILL, 1'b0);
    push(f + 28, "pre_areset",  M_L | M_S, 8'h0F, 7'h00, S_FILL, 1'b0);
    step(f + 28 - cyc);

    // Asynchronous reset between edges.
    #5 reset = 1'b1;
    #1;
    push(cyc, "async_reset", 4'hF, 8'h00, 7'h01, S_IDLE, 1'b0);
    ->chk_ev;
    step(1);
    reset = 1'b0; run = 1'b0;
    step(3);

    // Synchronous reseed.
    lfsr_reset = 1'b1;
    push(cyc + 1, "lfsr_reseed", M_V | M_S, 8'h00, 7'h01, S_IDLE, 1'b0);
    push(cyc + 2, "lfsr_after",  M_V | M_S, 8'h00, 7'h02, S_IDLE, 1'b0);
    step(1);
    lfsr_reset = 1'b0;
    step(3);

    total++;
    if (pulses != 2) begin
      bad++;
      $display("FAIL pulse_count: got %0d lfsr_begin pulses, want 2", pulses);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expectations never checked", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
